// File: rtl/imem_bridge.sv
// Single-outstanding fetch-to-memory read bridge with redirect discard and a sticky watchdog.
// Optional one-entry hit buffer in front of memory: define IMEM_BRIDGE_HIT_BUF_EN.
module imem_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] imem_addr,
    input  logic [3:0]  imem_rmask,
    input  logic        redirect,
    output logic [31:0] imem_rdata,
    output logic        imem_resp,
    output logic [31:0] mem_addr,
    output logic        mem_read,
    input  logic [31:0] mem_rdata,
    input  logic        mem_resp,
    output logic        timeout_err
);

    typedef enum logic [1:0] {IDLE, BUSY, DISCARD} state_t;

    localparam logic [15:0] WD_MAX = 16'(TIMEOUT_CYCLES);

    state_t      state;
    logic [15:0] wd_cnt;
    logic [15:0] wd_inc;
    logic        hit;
    logic        unused_addr_lsb;

    assign unused_addr_lsb = ^imem_addr[1:0];
    assign wd_inc = (wd_cnt == WD_MAX) ? wd_cnt : wd_cnt + 16'd1;

`ifdef IMEM_BRIDGE_HIT_BUF_EN
    // Data side of the buffer is imem_rdata itself: it always holds the last delivered word.
    logic [29:0] hit_tag;
    logic        hit_vld;
    assign hit = hit_vld && (hit_tag == imem_addr[31:2]);
`else
    assign hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            mem_read    <= 1'b0;
            mem_addr    <= 32'h0;
            imem_resp   <= 1'b0;
            imem_rdata  <= 32'h0000_0013;
            timeout_err <= 1'b0;
            wd_cnt      <= 16'd0;
`ifdef IMEM_BRIDGE_HIT_BUF_EN
            hit_tag     <= 30'h0;
            hit_vld     <= 1'b0;
`endif
        end else begin
            imem_resp <= 1'b0;
            case (state)
                IDLE: begin
                    if (imem_rmask != 4'h0) begin
                        if (hit) begin
                            imem_resp <= 1'b1;
                        end else begin
                            mem_addr <= {imem_addr[31:2], 2'b00};
                            mem_read <= 1'b1;
                            state    <= BUSY;
                            // The count includes the cycle being entered, so the error shows
                            // during the TIMEOUT_CYCLES-th waiting cycle.
                            wd_cnt   <= 16'd1;
                        end
                    end
                end
                BUSY, DISCARD: begin
                    if (mem_resp) begin
                        mem_read <= 1'b0;
                        state    <= IDLE;
                        wd_cnt   <= 16'd0;
                        if (state == BUSY && !redirect) begin
                            imem_rdata <= mem_rdata;
                            imem_resp  <= 1'b1;
`ifdef IMEM_BRIDGE_HIT_BUF_EN
                            hit_tag    <= mem_addr[31:2];
                            hit_vld    <= 1'b1;
`endif
                        end
                    end else begin
                        wd_cnt <= wd_inc;
                        if (wd_inc == WD_MAX) timeout_err <= 1'b1;
                        if (redirect) state <= DISCARD;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_bridge.sv
// Scoreboarded bench for imem_bridge: expected fetch words are queued when memory answers.
module tb_imem_bridge;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] imem_addr = '0;
    logic [3:0]  imem_rmask = '0;
    logic        redirect = 1'b0;
    logic [31:0] imem_rdata;
    logic        imem_resp;
    logic [31:0] mem_addr;
    logic        mem_read;
    logic [31:0] mem_rdata = '0;
    logic        mem_resp = 1'b0;
    logic        timeout_err;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] sb[$];

    always #5 clk = ~clk;

    imem_bridge #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst(rst),
        .imem_addr(imem_addr), .imem_rmask(imem_rmask), .redirect(redirect),
        .imem_rdata(imem_rdata), .imem_resp(imem_resp),
        .mem_addr(mem_addr), .mem_read(mem_read),
        .mem_rdata(mem_rdata), .mem_resp(mem_resp),
        .timeout_err(timeout_err)
    );

    // Advance one cycle; any response pulse is matched against the scoreboard.
    task automatic step();
        logic [31:0] exp;
        @(posedge clk);
        #1;
        if (imem_resp === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL resp_unexpected: got pulse data=%h, required no pulse", imem_rdata);
            end else begin
                exp = sb.pop_front();
                if (imem_rdata !== exp) begin
                    errors++;
                    $display("FAIL resp_data: got %h, required %h", imem_rdata, exp);
                end
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b0; imem_rmask = '0; redirect = 1'b0; mem_resp = 1'b0;
        sb.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic request(input logic [31:0] addr);
        imem_addr = addr;
        imem_rmask = 4'hF;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (mem_read !== 1'b0) begin errors++; $display("FAIL rst_mem_read: got %b, required 0", mem_read); end
        checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL rst_mem_addr: got %h, required 0", mem_addr); end
        checks++; if (imem_resp !== 1'b0) begin errors++; $display("FAIL rst_imem_resp: got %b, required 0", imem_resp); end
        checks++; if (imem_rdata !== 32'h13) begin errors++; $display("FAIL rst_imem_rdata: got %h, required 00000013", imem_rdata); end
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL rst_timeout: got %b, required 0", timeout_err); end
    endtask

    task automatic test_basic();
        do_reset();
        request(32'h6000_0000);
        step(); imem_rmask = '0;
        checks++; if (mem_read !== 1'b1) begin errors++; $display("FAIL basic_read_c1: got %b, required 1", mem_read); end
        checks++; if (mem_addr !== 32'h6000_0000) begin errors++; $display("FAIL basic_addr: got %h, required 60000000", mem_addr); end
        step(); step(); step();
        checks++; if (mem_read !== 1'b1) begin errors++; $display("FAIL basic_read_c4: got %b, required 1", mem_read); end
        mem_resp = 1'b1; mem_rdata = 32'h0000_0093; sb.push_back(32'h0000_0093);
        step(); mem_resp = 1'b0;
        checks++; if (imem_resp !== 1'b1) begin errors++; $display("FAIL basic_resp_c5: got %b, required 1", imem_resp); end
        checks++; if (mem_read !== 1'b0) begin errors++; $display("FAIL basic_read_c5: got %b, required 0", mem_read); end
        // Four BUSY cycles with TIMEOUT_CYCLES=4 trip the watchdog even though memory answered.
        checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL basic_wd_edge: got %b, required 1", timeout_err); end
        step();
        checks++; if (imem_resp !== 1'b0) begin errors++; $display("FAIL basic_pulse_len: got %b, required 0", imem_resp); end
        checks++; if (imem_rdata !== 32'h93) begin errors++; $display("FAIL basic_hold: got %h, required 00000093", imem_rdata); end
    endtask

    task automatic test_redirect();
        do_reset();
        request(32'h6000_0004);
        step(); imem_rmask = '0;
        step(); redirect = 1'b1;
        step();
        step(); redirect = 1'b0; mem_resp = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        checks++; if (mem_read !== 1'b1) begin errors++; $display("FAIL redir_hold: got %b, required 1", mem_read); end
        step(); mem_resp = 1'b0;
        checks++; if (mem_read !== 1'b0) begin errors++; $display("FAIL redir_drop: got %b, required 0", mem_read); end
        checks++; if (imem_rdata !== 32'h13) begin errors++; $display("FAIL redir_data: got %h, required 00000013", imem_rdata); end
        request(32'h6000_0100);
        step(); imem_rmask = '0;
        checks++; if (mem_read !== 1'b1) begin errors++; $display("FAIL redir_reissue: got %b, required 1", mem_read); end
        checks++; if (mem_addr !== 32'h6000_0100) begin errors++; $display("FAIL redir_addr: got %h, required 60000100", mem_addr); end
        mem_resp = 1'b1; mem_rdata = 32'h1111_0001; sb.push_back(32'h1111_0001);
        step(); mem_resp = 1'b0;
        checks++; if (imem_resp !== 1'b1) begin errors++; $display("FAIL redir_resp: got %b, required 1", imem_resp); end
    endtask

    task automatic test_same_cycle();
        do_reset();
        request(32'h6000_0010);
        step(); imem_rmask = '0; mem_resp = 1'b1; redirect = 1'b1; mem_rdata = 32'h0000_0BAD;
        step(); mem_resp = 1'b0; redirect = 1'b0;
        checks++; if (mem_read !== 1'b0) begin errors++; $display("FAIL same_drop: got %b, required 0", mem_read); end
        checks++; if (imem_resp !== 1'b0) begin errors++; $display("FAIL same_nopulse: got %b, required 0", imem_resp); end
        request(32'h6000_0014);
        step(); imem_rmask = '0;
        checks++; if (mem_addr !== 32'h6000_0014) begin errors++; $display("FAIL same_next_addr: got %h, required 60000014", mem_addr); end
        mem_resp = 1'b1; mem_rdata = 32'h0000_0213; sb.push_back(32'h0000_0213);
        step(); mem_resp = 1'b0;
        checks++; if (imem_resp !== 1'b1) begin errors++; $display("FAIL same_l0_resp: got %b, required 1", imem_resp); end
    endtask

    task automatic test_timeout();
        do_reset();
        request(32'h6000_0020);
        step(); imem_rmask = '0;
        step(); step();
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL wd_early: got %b, required 0", timeout_err); end
        step();
        checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL wd_set: got %b, required 1", timeout_err); end
        repeat (6) step();
        checks++; if (mem_read !== 1'b1 || timeout_err !== 1'b1) begin errors++; $display("FAIL wd_wait: got read=%b err=%b, required 1/1", mem_read, timeout_err); end
        mem_resp = 1'b1; mem_rdata = 32'h0040_0093; sb.push_back(32'h0040_0093);
        step(); mem_resp = 1'b0;
        checks++; if (imem_resp !== 1'b1) begin errors++; $display("FAIL wd_late_resp: got %b, required 1", imem_resp); end
        request(32'h6000_0024);
        step(); imem_rmask = '0; mem_resp = 1'b1; mem_rdata = 32'h0050_0113; sb.push_back(32'h0050_0113);
        step(); mem_resp = 1'b0;
        checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL wd_sticky: got %b, required 1", timeout_err); end
        do_reset();
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL wd_clear: got %b, required 0", timeout_err); end
    endtask

    task automatic test_reset_busy();
        do_reset();
        request(32'h6000_0030);
        step(); imem_rmask = '0;
        rst = 1'b0;
        #1;
        checks++; if (mem_read !== 1'b0 || imem_resp !== 1'b0) begin errors++; $display("FAIL rbusy_async: got read=%b resp=%b, required 0/0", mem_read, imem_resp); end
        checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL rbusy_addr: got %h, required 0", mem_addr); end
        mem_resp = 1'b1; mem_rdata = 32'h0000_0777;
        step(); rst = 1'b1;
        step(); step();
        mem_resp = 1'b0;
        checks++; if (mem_read !== 1'b0 || imem_rdata !== 32'h13) begin errors++; $display("FAIL rbusy_ignore: got read=%b data=%h, required 0/00000013", mem_read, imem_rdata); end
    endtask

    task automatic test_repeat();
        do_reset();
        request(32'h6000_0008);
        step(); imem_rmask = '0;
        step();
        step(); mem_resp = 1'b1; mem_rdata = 32'h00A0_0513; sb.push_back(32'h00A0_0513);
        step(); mem_resp = 1'b0;
        checks++; if (imem_resp !== 1'b1) begin errors++; $display("FAIL rep_first: got %b, required 1", imem_resp); end
        request(32'h6000_000A);
`ifdef IMEM_BRIDGE_HIT_BUF_EN
        sb.push_back(32'h00A0_0513);
        step(); imem_rmask = '0;
        checks++; if (imem_resp !== 1'b1) begin errors++; $display("FAIL hit_resp: got %b, required 1", imem_resp); end
        checks++; if (mem_read !== 1'b0) begin errors++; $display("FAIL hit_nomem: got %b, required 0", mem_read); end
`else
        step(); imem_rmask = '0;
        checks++; if (mem_read !== 1'b1) begin errors++; $display("FAIL rep_mem: got %b, required 1", mem_read); end
        checks++; if (mem_addr !== 32'h6000_0008) begin errors++; $display("FAIL rep_align: got %h, required 60000008", mem_addr); end
        mem_resp = 1'b1; mem_rdata = 32'h00A0_0513; sb.push_back(32'h00A0_0513);
        step(); mem_resp = 1'b0;
        checks++; if (imem_resp !== 1'b1) begin errors++; $display("FAIL rep_resp: got %b, required 1", imem_resp); end
`endif
        step();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_redirect();
        test_same_cycle();
        test_timeout();
        test_reset_busy();
        test_repeat();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: got %0d pending words, required 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
